// File: rtl/seq_mult_bcd_disp_pkg.sv
// Shared types, segment patterns and sizing helpers for seq_mult_bcd_disp.
package mult_disp_pkg;

    typedef enum logic [1:0] {IDLE, MULT, CONV, DONE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    // Decimal digits needed for the largest product of two width-bit operands.
    function automatic int bcd_digits_needed(input int width);
        longint unsigned max_val;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        max_val = max_val * max_val;
        n       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) s = SEG_DIGIT[d];
        return s;
    endfunction

endpackage

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per clock, IN_W steps per conversion.
module seq_bin2bcd
    import mult_disp_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [IN_W-1:0]        bin,
    output logic                   done,
    output logic [DIGITS-1:0][3:0] digits
);

    localparam int SR_W  = 4 * DIGITS + IN_W;
    localparam int CNT_W = $clog2(IN_W) + 1;

    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [SR_W-1:0]  sr_next;
    logic [CNT_W-1:0] step;
    logic             running;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it holding a stale value (latch).
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[IN_W + 4*i +: 4] >= 4'd5)
                sr_adj[IN_W + 4*i +: 4] = sr[IN_W + 4*i +: 4] + 4'd3;
        end
        sr_next = {sr_adj[SR_W-2:0], 1'b0};
    end

    // done flags the final step; digits show the post-step value so the caller can capture both on the same edge.
    assign done = running && (step == CNT_W'(IN_W - 1));

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign digits[i] = sr_next[IN_W + 4*i +: 4];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            step    <= '0;
            running <= 1'b0;
        end else if (start) begin
            sr      <= SR_W'(bin);
            step    <= '0;
            running <= 1'b1;
        end else if (running) begin
            sr   <= sr_next;
            step <= step + CNT_W'(1);
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_mult_bcd_disp.sv
// Shift-add multiplier with sequential BCD conversion and a multiplexed common-anode display.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant non-zero digit.
module seq_mult_bcd_disp
    import mult_disp_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 5,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [6:0]           seg,
    output logic [DIGITS-1:0]    an
);

    localparam int BCW  = $clog2(WIDTH) + 1;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW   = $clog2(REFRESH_DIV);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("WIDTH must be within 2..16");
    end
    if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_digits_check
        $error("DIGITS too small for the largest product");
    end
    if (REFRESH_DIV < 2) begin : g_refresh_check
        $error("REFRESH_DIV must be at least 2");
    end

    state_t                  state;
    logic [2*WIDTH-1:0]      mcand;
    logic [WIDTH-1:0]        mplier;
    logic [2*WIDTH-1:0]      acc;
    logic [2*WIDTH-1:0]      acc_next;
    logic [BCW-1:0]          bit_cnt;
    logic                    conv_start;
    logic                    conv_done;
    logic [DIGITS-1:0][3:0]  conv_digits;
    logic [DIGITS-1:0][3:0]  digit_q;

    assign acc_next   = acc + (mplier[0] ? mcand : '0);
    assign conv_start = (state == MULT) && (bit_cnt == BCW'(WIDTH - 1));

    seq_bin2bcd #(
        .IN_W   (2*WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start),
        .bin    (acc_next),
        .done   (conv_done),
        .digits (conv_digits)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_q;
    logic              above_zero;

    always_comb begin
        blank_next = '0;
        above_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            above_zero    = above_zero && (conv_digits[i] == 4'd0);
            blank_next[i] = above_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        else if (state == CONV && conv_done)
            blank_q <= blank_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            // NOTE: the digit store is reset because a reset must visibly clear the display back to 0.
            digit_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand   <= {{WIDTH{1'b0}}, a};
                        mplier  <= b;
                        acc     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= MULT;
                    end
                end
                MULT: begin
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + BCW'(1);
                    if (conv_start) state <= CONV;
                end
                CONV: begin
                    if (conv_done) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= acc;
                        digit_q <= conv_digits;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [RW-1:0]   refresh_cnt;
    logic [IDXW-1:0] scan_idx;
    logic [IDXW-1:0] scan_next;
    logic            refresh_wrap;
    logic [6:0]      seg_next;

    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));

    always_comb begin
        scan_next = scan_idx;
        if (refresh_wrap)
            scan_next = (scan_idx == IDXW'(DIGITS - 1)) ? '0 : scan_idx + IDXW'(1);
`ifdef LEADING_ZERO_BLANK_EN
        seg_next = blank_q[scan_next] ? SEG_BLANK : seg_decode(digit_q[scan_next]);
`else
        seg_next = seg_decode(digit_q[scan_next]);
`endif
    end

    // seg follows the stored digit every cycle, so it and an move together on a slot change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            an          <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg         <= SEG_DIGIT[0];
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
            scan_idx    <= scan_next;
            an          <= ~(DIGITS'(1) << scan_next);
            seg         <= seg_next;
        end
    end

endmodule

// File: tb/tb_seq_mult_bcd_disp.sv
// Scoreboard bench for seq_mult_bcd_disp: directed operands, product/latency monitor, display scan checks.
module tb_seq_mult_bcd_disp;

    localparam int D   = 5;
    localparam int LAT = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [6:0]  seg;
    logic [4:0]  an;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_count = 0;

    typedef struct {
        logic [15:0] prod;
        int          issue;
    } exp_t;
    exp_t sb_q[$];

    logic [6:0] seg_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic [7:0]  va [5] = '{8'd255, 8'd0,   8'd13, 8'd200, 8'd100};
    logic [7:0]  vb [5] = '{8'd255, 8'd173, 8'd7,  8'd3,   8'd250};
    logic [15:0] vp [5] = '{16'd65025, 16'd0, 16'd91, 16'd600, 16'd25000};
    logic [19:0] vd [5] = '{20'h65025, 20'h00000, 20'h00091, 20'h00600, 20'h25000};
    int          vx [5] = '{0, 0, 5, 0, 0};

    seq_mult_bcd_disp #(
        .WIDTH       (8),
        .DIGITS      (D),
        .REFRESH_DIV (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [19:0] dig, input int idx);
        logic       blank;
        logic [3:0] nib;
        nib   = dig[idx*4 +: 4];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx != 0);
        for (int i = idx; i < D; i++)
            if (dig[i*4 +: 4] != 4'd0) blank = 1'b0;
`endif
        return blank ? 7'h00 : seg_pat[nib];
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                check("done_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("product", 32'(product), 32'(e.prod));
                    check("latency", 32'(cyc - e.issue), 32'(LAT));
                end
            end
        end
    end

    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic [15:0] exp_prod, input int extra_at);
        exp_t e;
        @(posedge clk); #1;
        a = op_a; b = op_b; start = 1'b1;
        e.prod = exp_prod; e.issue = cyc;
        sb_q.push_back(e);
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            start = (k == extra_at);
            if (k == extra_at) begin
                a = 8'hFF; b = 8'hFF;
            end
            @(negedge clk);
            check("busy", 32'(busy), 32'((k >= 1 && k <= 24) ? 1 : 0));
        end
    endtask

    task automatic check_display(input logic [19:0] dig, input int n);
        int         idx;
        logic [4:0] exp_an;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            idx = 0;
            for (int i = 0; i < D; i++) if (an[i] == 1'b0) idx = i;
            exp_an = ~(5'd1 << idx);
            check("an_onehot", 32'(an), 32'(exp_an));
            check("seg_digit", 32'(seg), 32'(exp_seg(dig, idx)));
        end
    endtask

    initial begin
        int         base;
        int         idx;
        logic [4:0] exp_an;

        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_an", 32'(an), 32'h1E);
        check("rst_seg", 32'(seg), 32'h3F);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            base = done_count;
            do_op(va[v], vb[v], vp[v], vx[v]);
            check("done_pulses", 32'(done_count - base), 32'd1);
            check("sb_drained", 32'(sb_q.size()), 32'd0);
            check_display(vd[v], 22);
        end

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        a = 8'd200; b = 8'd201; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        base = done_count;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_an", 32'(an), 32'h1E);
        check("midrst_seg", 32'(seg), 32'h3F);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // Scan sequence from reset: slot advances every 4 cycles, wraps after digit 4.
        for (int m = 0; m < 24; m++) begin
            @(negedge clk);
            idx    = (m / 4) % D;
            exp_an = ~(5'd1 << idx);
            check("scan_an", 32'(an), 32'(exp_an));
            check("scan_seg", 32'(seg), 32'(exp_seg(20'h00000, idx)));
        end
        repeat (30) @(negedge clk);
        check("no_done_after_rst", 32'(done_count - base), 32'd0);
        check("sb_final", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
